mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_arb_select.sv | 31 +++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM encoding, requester slots, beat-count width.
package mem_port_arbiter_pkg;

   localparam int NUM_REQ    = 3;
   localparam int BEAT_W     = 3;

   localparam int REQ_IREAD  = 0;   // icache refill read
   localparam int REQ_DREAD  = 1;   // dcache read
   localparam int REQ_DWRITE = 2;   // dcache write-back / uncached write

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_RDATA = 3'd2,
      ST_WDATA = 3'd3,
      ST_WRESP = 3'd4
   } state_t;

endpackage

// File: rtl/mem_port_arbiter_arb_select.sv
// Winner select for the arbiter: write always wins; reads are round-robin when ARB_RR_EN
// is defined, otherwise fixed priority dcache read over icache read.
module arb_select
   import mem_port_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic               ptr,
   output logic [NUM_REQ-1:0] gnt
);

`ifdef ARB_RR_EN
   logic favour_iread;
   assign favour_iread = ptr;
`else
   logic favour_iread;
   logic unused_ptr;
   assign favour_iread = 1'b0;
   assign unused_ptr   = ptr;
`endif

   always_comb begin
      gnt = '0;
      if (req[REQ_DWRITE])
         gnt[REQ_DWRITE] = 1'b1;
      else if (req[REQ_DREAD] && !(req[REQ_IREAD] && favour_iread))
         gnt[REQ_DREAD] = 1'b1;
      else if (req[REQ_IREAD])
         gnt[REQ_IREAD] = 1'b1;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Three-requester memory port arbiter serialising burst reads/writes onto one bus.
// Define ARB_RR_EN for round-robin between the two read requesters.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      rq_req,
   input  logic [3*ADDR_W-1:0]     rq_addr,
   input  logic [3*BEAT_W-1:0]     rq_len,
   output logic [NUM_REQ-1:0]      rq_gnt,
   output logic [NUM_REQ-1:0]      rq_rvalid,
   output logic [31:0]             rq_rdata,
   output logic                    rq_last,
   input  logic [31:0]             rq_wdata,
   output logic                    rq_wready,
   output logic                    bus_req,
   output logic                    bus_wr,
   output logic [ADDR_W-1:0]       bus_addr,
   output logic [BEAT_W-1:0]       bus_len,
   input  logic                    bus_addr_ok,
   input  logic                    bus_rvalid,
   input  logic [31:0]             bus_rdata,
   output logic                    bus_wvalid,
   output logic [31:0]             bus_wdata,
   output logic                    bus_wlast,
   input  logic                    bus_wready,
   input  logic                    bus_bvalid,
   output logic [2:0]              state_dbg
);

   // Handshakes: an address phase completes when bus_req && bus_addr_ok, a write beat when
   // bus_wvalid && bus_wready, a read beat on bus_rvalid; the source holds its payload until then.
   state_t              state_q, state_d;
   logic [NUM_REQ-1:0]  win;
   logic                rr_ptr_q;
   logic [ADDR_W-1:0]   addr_q, sel_addr;
   logic [BEAT_W-1:0]   len_q, sel_len, cnt_q;
   logic                is_wr, cnt_zero;

   assign is_wr     = rq_gnt[REQ_DWRITE];
   assign cnt_zero  = (cnt_q == '0);
   assign state_dbg = state_q;

   arb_select u_arb_select (
      .req (rq_req),
      .ptr (rr_ptr_q),
      .gnt (win)
   );

   always_comb begin
      sel_addr = '0;
      sel_len  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win[i]) begin
            sel_addr = rq_addr[i*ADDR_W +: ADDR_W];
            sel_len  = rq_len[i*BEAT_W +: BEAT_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      bus_req    = 1'b0;
      bus_wr     = 1'b0;
      bus_addr   = '0;
      bus_len    = '0;
      bus_wvalid = 1'b0;
      bus_wdata  = '0;
      bus_wlast  = 1'b0;
      rq_wready  = 1'b0;
      rq_rvalid  = '0;
      rq_rdata   = '0;
      rq_last    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|rq_req) state_d = ST_ADDR;
         end
         ST_ADDR: begin
            bus_req  = 1'b1;
            bus_wr   = is_wr;
            bus_addr = addr_q;
            bus_len  = len_q;
            if (bus_addr_ok) state_d = is_wr ? ST_WDATA : ST_RDATA;
         end
         ST_RDATA: begin
            rq_rdata  = bus_rdata;
            rq_rvalid = bus_rvalid ? rq_gnt : '0;
            rq_last   = bus_rvalid && cnt_zero;
            if (bus_rvalid && cnt_zero) state_d = ST_IDLE;
         end
         ST_WDATA: begin
            bus_wvalid = 1'b1;
            bus_wdata  = rq_wdata;
            bus_wlast  = cnt_zero;
            rq_wready  = bus_wready;
            rq_last    = bus_wready && cnt_zero;
            if (bus_wready && cnt_zero) state_d = ST_WRESP;
         end
         ST_WRESP: begin
            if (bus_bvalid) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rq_gnt   <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         rr_ptr_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|rq_req) begin
                  rq_gnt <= win;
                  addr_q <= sel_addr;
                  len_q  <= sel_len;
                  // After a dcache read grant favour the icache next, and vice versa.
                  if (!win[REQ_DWRITE]) rr_ptr_q <= win[REQ_DREAD];
               end
            end
            ST_ADDR: begin
               if (bus_addr_ok) cnt_q <= len_q;
            end
            ST_RDATA: begin
               if (bus_rvalid) begin
                  if (cnt_zero) rq_gnt <= '0;
                  else          cnt_q  <= cnt_q - 1'b1;
               end
            end
            ST_WDATA: begin
               if (bus_wready && !cnt_zero) cnt_q <= cnt_q - 1'b1;
            end
            ST_WRESP: begin
               if (bus_bvalid) rq_gnt <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; grant-order expectations follow ARB_RR_EN.
module tb_mem_port_arbiter;

   localparam int ADDR_W = 32;

   logic              clk;
   logic              reset;
   logic [2:0]        rq_req;
   logic [3*ADDR_W-1:0] rq_addr;
   logic [8:0]        rq_len;
   logic [2:0]        rq_gnt;
   logic [2:0]        rq_rvalid;
   logic [31:0]       rq_rdata;
   logic              rq_last;
   logic [31:0]       rq_wdata;
   logic              rq_wready;
   logic              bus_req;
   logic              bus_wr;
   logic [ADDR_W-1:0] bus_addr;
   logic [2:0]        bus_len;
   logic              bus_addr_ok;
   logic              bus_rvalid;
   logic [31:0]       bus_rdata;
   logic              bus_wvalid;
   logic [31:0]       bus_wdata;
   logic              bus_wlast;
   logic              bus_wready;
   logic              bus_bvalid;
   logic [2:0]        state_dbg;

   int total = 0;
   int bad   = 0;

   mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset),
      .rq_req(rq_req), .rq_addr(rq_addr), .rq_len(rq_len),
      .rq_gnt(rq_gnt), .rq_rvalid(rq_rvalid), .rq_rdata(rq_rdata), .rq_last(rq_last),
      .rq_wdata(rq_wdata), .rq_wready(rq_wready),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_len(bus_len),
      .bus_addr_ok(bus_addr_ok), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
      .bus_wvalid(bus_wvalid), .bus_wdata(bus_wdata), .bus_wlast(bus_wlast),
      .bus_wready(bus_wready), .bus_bvalid(bus_bvalid), .state_dbg(state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_slot(input int slot, input logic [31:0] addr, input logic [2:0] len);
      rq_addr[slot*ADDR_W +: ADDR_W] = addr;
      rq_len[slot*3 +: 3]            = len;
   endtask

   logic [2:0] exp_gnt [4];
   logic [31:0] exp_addr;

   initial begin
      reset = 1'b1; rq_req = '0; rq_addr = '0; rq_len = '0; rq_wdata = '0;
      bus_addr_ok = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_wready = 1'b0; bus_bvalid = 1'b0;
`ifdef ARB_RR_EN
      exp_gnt[0] = 3'b010; exp_gnt[1] = 3'b001; exp_gnt[2] = 3'b010; exp_gnt[3] = 3'b001;
`else
      exp_gnt[0] = 3'b010; exp_gnt[1] = 3'b010; exp_gnt[2] = 3'b010; exp_gnt[3] = 3'b010;
`endif
      cyc(); cyc();
      settle();
      chk("rst_state", state_dbg, 0);
      chk("rst_gnt", rq_gnt, 0);
      chk("rst_bus_req", bus_req, 0);
      chk("rst_wvalid", bus_wvalid, 0);
      chk("rst_last", rq_last, 0);

      // single 8-beat dcache read, address accepted one cycle late
      reset = 1'b0;
      rq_req = 3'b010; set_slot(1, 32'h1FC0_0100, 3'd7);
      settle();
      chk("a_c0_gnt", rq_gnt, 0);
      chk("a_c0_bus_req", bus_req, 0);
      cyc(); settle();
      chk("a_c1_gnt", rq_gnt, 3'b010);
      chk("a_c1_bus_req", bus_req, 1);
      chk("a_c1_addr", bus_addr, 32'h1FC0_0100);
      chk("a_c1_len", bus_len, 7);
      chk("a_c1_wr", bus_wr, 0);
      cyc(); bus_addr_ok = 1'b1; settle();
      chk("a_c2_bus_req", bus_req, 1);
      cyc(); bus_addr_ok = 1'b0; settle();
      chk("a_c3_bus_req", bus_req, 0);
      for (int k = 0; k < 8; k++) begin
         if (k > 0) cyc();
         if (k == 4) begin
            bus_rvalid = 1'b0; settle();
            chk("a_stall_rvalid", rq_rvalid, 0);
            cyc();
         end
         bus_rvalid = 1'b1; bus_rdata = 32'hA000_0000 + k;
         settle();
         chk("a_rvalid", rq_rvalid, 3'b010);
         chk("a_rdata", rq_rdata, 32'hA000_0000 + k);
         chk("a_last", rq_last, (k == 7));
      end
      cyc(); bus_rvalid = 1'b0; rq_req = 3'b000; settle();
      chk("a_end_gnt", rq_gnt, 0);
      chk("a_end_state", state_dbg, 0);
      cyc(); settle();
      chk("a_idle_gnt", rq_gnt, 0);

      // write and read together: write first, read only after response + one idle
      rq_req = 3'b110; set_slot(1, 32'h0000_1000, 3'd0); set_slot(2, 32'h0000_2000, 3'd7);
      settle();
      cyc(); bus_addr_ok = 1'b1; settle();
      chk("b_gnt_wr", rq_gnt, 3'b100);
      chk("b_bus_wr", bus_wr, 1);
      chk("b_addr", bus_addr, 32'h0000_2000);
      chk("b_len", bus_len, 7);
      cyc(); bus_addr_ok = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) cyc();
         rq_wdata = 32'hB000_0000 + k; bus_wready = 1'b1; bus_rvalid = 1'b1;
         bus_bvalid = (k == 3);
         settle();
         chk("b_wvalid", bus_wvalid, 1);
         chk("b_wdata", bus_wdata, 32'hB000_0000 + k);
         chk("b_wlast", bus_wlast, (k == 7));
         chk("b_rq_wready", rq_wready, 1);
         chk("b_rq_last", rq_last, (k == 7));
         chk("b_no_rvalid", rq_rvalid, 0);
      end
      cyc(); bus_wready = 1'b0; bus_rvalid = 1'b0; bus_bvalid = 1'b0; rq_req = 3'b010; settle();
      chk("b_wresp_state", state_dbg, 4);
      chk("b_wresp_wvalid", bus_wvalid, 0);
      chk("b_wresp_gnt", rq_gnt, 3'b100);
      cyc(); bus_bvalid = 1'b1; settle();
      chk("b_bvalid_gnt", rq_gnt, 3'b100);
      cyc(); bus_bvalid = 1'b0; settle();
      chk("b_idle_state", state_dbg, 0);
      chk("b_idle_gnt", rq_gnt, 0);
      chk("b_idle_bus_req", bus_req, 0);
      cyc(); bus_addr_ok = 1'b1; settle();
      chk("b_rd_gnt", rq_gnt, 3'b010);
      chk("b_rd_bus_wr", bus_wr, 0);
      chk("b_rd_addr", bus_addr, 32'h0000_1000);
      chk("b_rd_len", bus_len, 0);
      cyc(); bus_addr_ok = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_0001; settle();
      chk("b_rd_rvalid", rq_rvalid, 3'b010);
      chk("b_rd_last", rq_last, 1);
      chk("b_rd_rdata", rq_rdata, 32'hCAFE_0001);
      cyc(); bus_rvalid = 1'b0; rq_req = 3'b000; settle();
      chk("b_end_gnt", rq_gnt, 0);

      // single-beat write with bus_wready held low for 3 cycles
      cyc(); rq_req = 3'b100; set_slot(2, 32'h0000_3000, 3'd0); settle();
      cyc(); bus_addr_ok = 1'b1; settle();
      chk("c_bus_wr", bus_wr, 1);
      chk("c_len", bus_len, 0);
      cyc(); bus_addr_ok = 1'b0; rq_wdata = 32'h5A5A_5A5A; bus_wready = 1'b0;
      for (int j = 0; j < 3; j++) begin
         if (j > 0) cyc();
         settle();
         chk("c_hold_wvalid", bus_wvalid, 1);
         chk("c_hold_wlast", bus_wlast, 1);
         chk("c_hold_wready", rq_wready, 0);
         chk("c_hold_last", rq_last, 0);
      end
      cyc(); bus_wready = 1'b1; settle();
      chk("c_acc_wready", rq_wready, 1);
      chk("c_acc_last", rq_last, 1);
      chk("c_acc_wdata", bus_wdata, 32'h5A5A_5A5A);
      cyc(); bus_wready = 1'b0; rq_req = 3'b000; settle();
      chk("c_wresp_state", state_dbg, 4);
      chk("c_wresp_wvalid", bus_wvalid, 0);
      chk("c_wresp_wready", rq_wready, 0);
      cyc(); bus_bvalid = 1'b1; settle();
      cyc(); bus_bvalid = 1'b0; settle();
      chk("c_idle_state", state_dbg, 0);
      chk("c_idle_gnt", rq_gnt, 0);

      // both readers held for four transactions, starting from a fresh reset
      cyc(); reset = 1'b1;
      cyc(); reset = 1'b0;
      rq_req = 3'b011; set_slot(0, 32'h0000_0100, 3'd0); set_slot(1, 32'h0000_0200, 3'd0);
      settle();
      for (int t = 0; t < 4; t++) begin
         exp_addr = (exp_gnt[t] == 3'b001) ? 32'h0000_0100 : 32'h0000_0200;
         cyc(); settle();
         chk("d_gnt", rq_gnt, exp_gnt[t]);
         chk("d_addr", bus_addr, exp_addr);
         bus_addr_ok = 1'b1;
         cyc(); bus_addr_ok = 1'b0; bus_rvalid = 1'b1; settle();
         chk("d_rvalid", rq_rvalid, exp_gnt[t]);
         chk("d_last", rq_last, 1);
         cyc(); bus_rvalid = 1'b0; settle();
         chk("d_idle_gnt", rq_gnt, 0);
         if (t == 3) rq_req = 3'b000;
      end

      // reset on the third beat of an 8-beat read
      cyc(); rq_req = 3'b010; set_slot(1, 32'h1FC0_0200, 3'd7); settle();
      cyc(); bus_addr_ok = 1'b1; settle();
      cyc(); bus_addr_ok = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) cyc();
         bus_rvalid = 1'b1; bus_rdata = 32'hD000_0000 + k;
         if (k == 2) reset = 1'b1;
         settle();
         chk("e_rvalid", rq_rvalid, 3'b010);
         chk("e_last", rq_last, 0);
      end
      cyc(); reset = 1'b0; rq_req = 3'b000; bus_rvalid = 1'b1; settle();
      chk("e_rst_state", state_dbg, 0);
      chk("e_rst_gnt", rq_gnt, 0);
      chk("e_rst_bus_req", bus_req, 0);
      chk("e_rst_rvalid", rq_rvalid, 0);
      chk("e_rst_last", rq_last, 0);
      chk("e_rst_rdata", rq_rdata, 0);
      cyc(); settle();
      chk("e_after_state", state_dbg, 0);
      chk("e_after_rvalid", rq_rvalid, 0);
      bus_rvalid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
